smiley_collision_arbiter: RTL and testbench

- Per-frame collision arbiter/sequencer in front of the smiley controller.
- Latches raw collision pulses (top/left/right border, flipper, obstacle) over one video frame and picks a single winner at startOfFrame by fixed priority.
- Holds the winner as a one-hot grant for the whole next frame, so the smiley motion logic sees at most one bounce per frame.
- Applies a per-source cooldown so a ball still overlapping an object is not re-bounced every frame.

---
 rtl/smiley_collision_arbiter_if.sv | 30 +++
 rtl/smiley_collision_arbiter.sv | 146 ++++++++++++++
 tb/tb_smiley_collision_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/smiley_collision_arbiter_if.sv
// Bus between the game logic and the smiley collision arbiter: frame control,
// raw collision pulses in, one-hot grant and statistics out.
interface smiley_collision_arbiter_if;
    logic       startOfFrame;
    logic       pause;
    logic       reset_level;
    logic       collisionSmileyBorderTop;
    logic       collisionSmileyBorderLeft;
    logic       collisionSmileyBorderRight;
    logic       collisionSmileyFlipper;
    logic       collisionSmileyObstacle;
    logic [4:0] grant;
    logic       grantValid;
    logic       collisionSmileyObstacleReal;
    logic [7:0] droppedCount;

    modport master (
        output startOfFrame, pause, reset_level,
        output collisionSmileyBorderTop, collisionSmileyBorderLeft, collisionSmileyBorderRight,
        output collisionSmileyFlipper, collisionSmileyObstacle,
        input  grant, grantValid, collisionSmileyObstacleReal, droppedCount
    );

    modport slave (
        input  startOfFrame, pause, reset_level,
        input  collisionSmileyBorderTop, collisionSmileyBorderLeft, collisionSmileyBorderRight,
        input  collisionSmileyFlipper, collisionSmileyObstacle,
        output grant, grantValid, collisionSmileyObstacleReal, droppedCount
    );
endinterface

// File: rtl/smiley_collision_arbiter.sv
// Per-frame collision arbiter: collects collisions over a frame, grants one winner for the next
// frame with per-source cooldown. Define SMILEY_ARB_DROP_STATS_EN to build the droppedCount counter.
module smiley_collision_arbiter #(
    parameter int COOLDOWN_FRAMES = 4,
    parameter int CNT_W           = 3
) (
    input  logic                      clk,
    input  logic                      resetN,
    smiley_collision_arbiter_if.slave bus
);
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_e;

    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q, state_d;
    logic [4:0]       pending_q, pending_d;
    logic [4:0]       grant_q, grant_d;
    logic             obst_q, obst_d;
    logic [CNT_W-1:0] cool_q [5];
    logic [CNT_W-1:0] cool_d [5];

    logic [4:0]       raw;
    logic [4:0]       cool_idle;
    logic [4:0]       winner;
    logic             arb_fire;

    // Bit order {Right, Left, Top, Obstacle, Flipper}: lowest set bit has highest priority.
    assign raw = {bus.collisionSmileyBorderRight, bus.collisionSmileyBorderLeft,
                  bus.collisionSmileyBorderTop, bus.collisionSmileyObstacle,
                  bus.collisionSmileyFlipper};
    assign winner = pending_q & (~pending_q + 5'd1);

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            cool_idle[i] = (cool_q[i] == '0);
        end
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned and infers a latch.
        state_d   = state_q;
        pending_d = pending_q;
        grant_d   = grant_q;
        obst_d    = 1'b0;
        cool_d    = cool_q;
        arb_fire  = 1'b0;

        if (bus.reset_level) begin
            state_d   = ST_RUN;
            pending_d = '0;
            grant_d   = '0;
            for (int i = 0; i < 5; i++) begin
                cool_d[i] = '0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.startOfFrame && bus.pause) begin
                        state_d   = ST_PAUSED;
                        pending_d = '0;
                        grant_d   = '0;
                    end else if (bus.startOfFrame) begin
                        arb_fire = 1'b1;
                    end else begin
                        pending_d = pending_q | (raw & cool_idle);
                    end
                end
                ST_PAUSED: begin
                    if (bus.startOfFrame && !bus.pause) begin
                        state_d  = ST_RUN;
                        arb_fire = 1'b1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end

        if (arb_fire) begin
            grant_d   = winner;
            pending_d = '0;
            obst_d    = winner[1];
            for (int i = 0; i < 5; i++) begin
                if (winner[i]) begin
                    cool_d[i] = COOL_LOAD;
                end else if (!cool_idle[i]) begin
                    cool_d[i] = cool_q[i] - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q   <= ST_RUN;
            pending_q <= '0;
            grant_q   <= '0;
            obst_q    <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                cool_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            obst_q    <= obst_d;
            cool_q    <= cool_d;
        end
    end

    assign bus.grant                       = grant_q;
    assign bus.grantValid                  = |grant_q;
    assign bus.collisionSmileyObstacleReal = obst_q;

`ifdef SMILEY_ARB_DROP_STATS_EN
    logic [7:0] drop_q, drop_d;
    logic [4:0] losers;
    logic [8:0] drop_sum;

    // Survives reset_level; only the hard reset clears the statistic.
    always_comb begin
        losers   = pending_q & ~winner;
        drop_sum = {1'b0, drop_q} + 9'($countones(losers));
        drop_d   = drop_q;
        if (arb_fire) begin
            drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign bus.droppedCount = drop_q;
`else
    assign bus.droppedCount = '0;
`endif
endmodule

// File: tb/tb_smiley_collision_arbiter.sv
// Self-checking bench: two arbiters (cooldown 4 and cooldown 0) share directed and random stimulus
// and are compared every cycle against a frame-level reference model.
module tb_smiley_collision_arbiter;
`ifdef SMILEY_ARB_DROP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetN;
    logic       sof, pause_v, rl;
    logic [4:0] raw_v;   // {Right, Left, Top, Obstacle, Flipper}

    int n_checks = 0;
    int n_pass   = 0;
    int obst_pulses_a = 0;

    always #5 clk = ~clk;

    smiley_collision_arbiter_if bus_a ();
    smiley_collision_arbiter_if bus_b ();

    assign bus_a.startOfFrame               = sof;
    assign bus_a.pause                      = pause_v;
    assign bus_a.reset_level                = rl;
    assign bus_a.collisionSmileyFlipper     = raw_v[0];
    assign bus_a.collisionSmileyObstacle    = raw_v[1];
    assign bus_a.collisionSmileyBorderTop   = raw_v[2];
    assign bus_a.collisionSmileyBorderLeft  = raw_v[3];
    assign bus_a.collisionSmileyBorderRight = raw_v[4];

    assign bus_b.startOfFrame               = sof;
    assign bus_b.pause                      = pause_v;
    assign bus_b.reset_level                = rl;
    assign bus_b.collisionSmileyFlipper     = raw_v[0];
    assign bus_b.collisionSmileyObstacle    = raw_v[1];
    assign bus_b.collisionSmileyBorderTop   = raw_v[2];
    assign bus_b.collisionSmileyBorderLeft  = raw_v[3];
    assign bus_b.collisionSmileyBorderRight = raw_v[4];

    smiley_collision_arbiter #(.COOLDOWN_FRAMES(4), .CNT_W(3)) dut_a (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus_a)
    );

    smiley_collision_arbiter #(.COOLDOWN_FRAMES(0), .CNT_W(3)) dut_b (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus_b)
    );

    // Reference model, one slot per instance.
    int m_cd    [2] = '{4, 0};
    int m_cool  [2][5];
    bit m_pend  [2][5];
    bit m_paused[2];
    int m_grant [2];
    int m_drop  [2];
    bit m_obst  [2];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 5; i++) begin
                m_cool[k][i] = 0;
                m_pend[k][i] = 1'b0;
            end
            m_paused[k] = 1'b0;
            m_grant[k]  = 0;
            m_drop[k]   = 0;
            m_obst[k]   = 1'b0;
        end
    endtask

    task automatic model_step(input int k);
        int w;
        int n;
        m_obst[k] = 1'b0;
        if (rl) begin
            for (int i = 0; i < 5; i++) begin
                m_pend[k][i] = 1'b0;
                m_cool[k][i] = 0;
            end
            m_grant[k]  = 0;
            m_paused[k] = 1'b0;
        end else if (sof && pause_v) begin
            if (!m_paused[k]) begin
                for (int i = 0; i < 5; i++) m_pend[k][i] = 1'b0;
                m_grant[k]  = 0;
                m_paused[k] = 1'b1;
            end
        end else if (sof) begin
            // Priority Flipper, Obstacle, Top, Left, Right == ascending bit index.
            w = -1;
            n = 0;
            for (int p = 0; p < 5; p++) begin
                if (m_pend[k][p]) begin
                    n++;
                    if (w < 0) w = p;
                end
            end
            m_grant[k] = (w >= 0) ? (1 << w) : 0;
            if (w >= 0) n--;
            m_drop[k] = (m_drop[k] + n > 255) ? 255 : m_drop[k] + n;
            for (int i = 0; i < 5; i++) begin
                if (i == w) m_cool[k][i] = m_cd[k];
                else if (m_cool[k][i] > 0) m_cool[k][i]--;
                m_pend[k][i] = 1'b0;
            end
            m_obst[k]   = (w == 1);
            m_paused[k] = 1'b0;
        end else if (!m_paused[k]) begin
            for (int i = 0; i < 5; i++) begin
                if (raw_v[i] && m_cool[k][i] == 0) m_pend[k][i] = 1'b1;
            end
        end
    endtask

    function automatic int exp_drop(input int k);
        return STATS ? m_drop[k] : 0;
    endfunction

    task automatic compare_all();
        check("grant_a", int'(bus_a.grant), m_grant[0]);
        check("valid_a", int'(bus_a.grantValid), int'(m_grant[0] != 0));
        check("obst_a", int'(bus_a.collisionSmileyObstacleReal), int'(m_obst[0]));
        check("drop_a", int'(bus_a.droppedCount), exp_drop(0));
        check("grant_b", int'(bus_b.grant), m_grant[1]);
        check("valid_b", int'(bus_b.grantValid), int'(m_grant[1] != 0));
        check("obst_b", int'(bus_b.collisionSmileyObstacleReal), int'(m_obst[1]));
        check("drop_b", int'(bus_b.droppedCount), exp_drop(1));
    endtask

    // Called at a negative edge: drive, clock, advance model, sample at the next negative edge.
    task automatic run_cycle(input logic s, input logic p, input logic r, input logic [4:0] c);
        sof = s; pause_v = p; rl = r; raw_v = c;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
        if (bus_a.collisionSmileyObstacleReal) obst_pulses_a++;
    endtask

    task automatic run_frame(input int len, input logic p, input logic [4:0] sof_raw,
                             input logic [4:0] body_raw);
        run_cycle(1'b1, p, 1'b0, sof_raw);
        repeat (len - 1) run_cycle(1'b0, p, 1'b0, body_raw);
    endtask

    initial begin
        resetN = 1'b0; sof = 1'b0; pause_v = 1'b0; rl = 1'b0; raw_v = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        compare_all();
        resetN = 1'b1;

        // Flipper and Top in the same frame: Flipper wins, Top is dropped.
        run_frame(8, 1'b0, 5'b0, 5'b0);
        run_cycle(1'b1, 1'b0, 1'b0, 5'b0);
        run_cycle(1'b0, 1'b0, 1'b0, 5'b00101);
        repeat (5) run_cycle(1'b0, 1'b0, 1'b0, 5'b0);
        run_cycle(1'b1, 1'b0, 1'b0, 5'b0);
        check("s1_grant", int'(bus_a.grant), 1);
        check("s1_valid", int'(bus_a.grantValid), 1);
        check("s1_drop", int'(bus_a.droppedCount), STATS ? 1 : 0);
        repeat (6) run_frame(6, 1'b0, 5'b0, 5'b0);

        // Obstacle held for frames 0..10: granted in frames 1, 6 and 11 with cooldown 4.
        obst_pulses_a = 0;
        for (int f = 0; f < 12; f++) begin
            run_frame(8, 1'b0, (f <= 10) ? 5'b00010 : 5'b0, (f <= 10) ? 5'b00010 : 5'b0);
        end
        check("s2_pulses", obst_pulses_a, 3);
        repeat (6) run_frame(6, 1'b0, 5'b0, 5'b0);

        // Left only in the startOfFrame cycle is not collected.
        run_cycle(1'b1, 1'b0, 1'b0, 5'b01000);
        repeat (5) run_cycle(1'b0, 1'b0, 1'b0, 5'b0);
        run_cycle(1'b1, 1'b0, 1'b0, 5'b0);
        check("s3_grant", int'(bus_a.grant), 0);
        repeat (5) run_cycle(1'b0, 1'b0, 1'b0, 5'b0);

        // Pause with Right pending discards it; Right after resume is granted.
        run_cycle(1'b1, 1'b0, 1'b0, 5'b0);
        run_cycle(1'b0, 1'b0, 1'b0, 5'b10000);
        repeat (4) run_cycle(1'b0, 1'b0, 1'b0, 5'b0);
        run_cycle(1'b1, 1'b1, 1'b0, 5'b0);
        check("s4_pause_grant", int'(bus_a.grant), 0);
        check("s4_pause_valid", int'(bus_a.grantValid), 0);
        repeat (5) run_cycle(1'b0, 1'b1, 1'b0, 5'b10000);
        run_frame(6, 1'b1, 5'b10000, 5'b10000);
        run_cycle(1'b1, 1'b0, 1'b0, 5'b0);
        check("s4_resume_grant", int'(bus_a.grant), 0);
        run_cycle(1'b0, 1'b0, 1'b0, 5'b10000);
        repeat (4) run_cycle(1'b0, 1'b0, 1'b0, 5'b0);
        run_cycle(1'b1, 1'b0, 1'b0, 5'b0);
        check("s4_right_grant", int'(bus_a.grant), 16);

        // reset_level together with startOfFrame: Top pending, Right cooling down.
        run_cycle(1'b0, 1'b0, 1'b0, 5'b00100);
        repeat (3) run_cycle(1'b0, 1'b0, 1'b0, 5'b0);
        run_cycle(1'b1, 1'b0, 1'b1, 5'b0);
        check("s5_grant", int'(bus_a.grant), 0);
        check("s5_drop", int'(bus_a.droppedCount), exp_drop(0));
        run_cycle(1'b0, 1'b0, 1'b0, 5'b10000);
        repeat (4) run_cycle(1'b0, 1'b0, 1'b0, 5'b0);
        run_cycle(1'b1, 1'b0, 1'b0, 5'b0);
        check("s5_cool_cleared", int'(bus_a.grant), 16);

        // Asynchronous reset mid-frame.
        run_cycle(1'b0, 1'b0, 1'b0, 5'b00001);
        #2 resetN = 1'b0;
        #1;
        model_reset();
        compare_all();
        @(negedge clk);
        resetN = 1'b1;
        run_frame(6, 1'b0, 5'b0, 5'b00001);
        check("s6_first_sof", int'(bus_a.grant), 0);
        run_cycle(1'b1, 1'b0, 1'b0, 5'b0);
        check("s6_second_sof", int'(bus_a.grant), 1);

        // Randomised frames.
        for (int f = 0; f < 150; f++) begin
            int   len;
            logic p;
            len = $urandom_range(4, 12);
            p   = ($urandom_range(0, 5) == 0);
            for (int c = 0; c < len; c++) begin
                logic [4:0] r;
                for (int i = 0; i < 5; i++) r[i] = ($urandom_range(0, 7) == 0);
                run_cycle(c == 0, p, $urandom_range(0, 99) == 0, r);
            end
        end

        // All sources high for 300 frames: drop counter saturates.
        repeat (300) run_frame(3, 1'b0, 5'b11111, 5'b11111);
        check("s8_sat_b", int'(bus_b.droppedCount), STATS ? 255 : 0);
        check("s8_sat_a", int'(bus_a.droppedCount), STATS ? 255 : 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
